// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: a - b processed DIGIT bits per clock with a registered borrow.
// Optional build macro: SUBTRACTOR_SATURATE_EN clamps an underflowed result to zero.
module serial_subtractor #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIGIT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int unsigned N    = WIDTH / DIGIT;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("DIGIT must divide WIDTH");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic              borrow_q, borrow_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DIGIT:0]    digit_diff;
   logic [WIDTH-1:0]  diff_res;
   int unsigned       idx;
   logic              done;

   assign idx = 32'(cnt_q) * DIGIT;
   // Extra MSB of the digit difference is the borrow out of this digit.
   assign digit_diff = {1'b0, a_q[idx +: DIGIT]} - {1'b0, b_q[idx +: DIGIT]}
                       - {{DIGIT{1'b0}}, borrow_q};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               res_d    = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            res_d[idx +: DIGIT] = digit_diff[DIGIT-1:0];
            borrow_d            = digit_diff[DIGIT];
            cnt_d               = cnt_q + 1'b1;
            if (cnt_q == CntW'(N - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef SUBTRACTOR_SATURATE_EN
   assign diff_res = borrow_q ? '0 : res_q;
`else
   assign diff_res = res_q;
`endif

   assign done      = (state_q == StDone);
   assign in_ready  = (state_q == StIdle) && !reset;
   assign out_valid = done;
   assign diff      = done ? diff_res : '0;
   assign borrow    = done & borrow_q;
   assign zero      = done & (diff_res == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (64/8 instance plus a 16/16 single-digit one).
`timescale 1ns/1ps
module tb_serial_subtractor;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, borrow, zero;
   logic [63:0] a, b, diff;
   logic        in_valid1, in_ready1, out_valid1, out_ready1, borrow1, zero1;
   logic [15:0] a1, b1, diff1;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   serial_subtractor #(.WIDTH(64), .DIGIT(8)) u_dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow), .zero(zero)
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_n1 (
      .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1),
      .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .diff(diff1), .borrow(borrow1),
      .zero(zero1)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Accepts one operand pair on the 64-bit instance; lat counts cycles until out_valid.
   task automatic start_op(input logic [63:0] av, input logic [63:0] bv, output int lat);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      step();
      in_valid = 1'b0;
      a        = ~av;
      b        = 64'h0123_4567_89AB_CDEF;
      lat      = 1;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b1;
      a        = 64'd9;
      b        = 64'd1;
      repeat (3) step();
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
      end
      checks++;
      if ({out_valid, borrow, zero} !== 3'b000 || diff !== 64'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b%b%b/%h exp=000/0", out_valid, borrow, zero, diff);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready);
      end
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_no_accept got=%b%b exp=10", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      int lat;
      start_op(64'd5, 64'd3, lat);
      checks++;
      if (lat !== 9) begin
         failures++; $display("FAIL basic_latency got=%0d exp=9", lat);
      end
      checks++;
      if (diff !== 64'd2 || borrow !== 1'b0 || zero !== 1'b0) begin
         failures++; $display("FAIL basic_result got=%h/%b/%b exp=2/0/0", diff, borrow, zero);
      end
      drain();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL basic_handoff got=%b%b exp=01", out_valid, in_ready);
      end
   endtask

   task automatic test_underflow();
      int lat;
      logic [63:0] exp_d;
      logic        exp_z;
`ifdef SUBTRACTOR_SATURATE_EN
      exp_d = 64'd0;
      exp_z = 1'b1;
`else
      exp_d = 64'h0000_0000_0000_AAAA;
      exp_z = 1'b0;
`endif
      start_op(64'd0, 64'hFFFF_FFFF_FFFF_5556, lat);
      checks++;
      if (diff !== exp_d || borrow !== 1'b1 || zero !== exp_z) begin
         failures++;
         $display("FAIL underflow got=%h/%b/%b exp=%h/1/%b", diff, borrow, zero, exp_d, exp_z);
      end
      drain();
   endtask

   task automatic test_equal_and_chain();
      int lat;
      start_op(64'h1234, 64'h1234, lat);
      checks++;
      if (diff !== 64'd0 || borrow !== 1'b0 || zero !== 1'b1) begin
         failures++; $display("FAIL equal got=%h/%b/%b exp=0/0/1", diff, borrow, zero);
      end
      drain();
      start_op(64'h100, 64'h1, lat);
      checks++;
      if (diff !== 64'hFF || borrow !== 1'b0 || zero !== 1'b0) begin
         failures++; $display("FAIL chain got=%h/%b/%b exp=ff/0/0", diff, borrow, zero);
      end
      drain();
      start_op(64'h8000_0000_0000_0000, 64'h1, lat);
      checks++;
      if (diff !== 64'h7FFF_FFFF_FFFF_FFFF || borrow !== 1'b0) begin
         failures++; $display("FAIL chain_full got=%h/%b exp=7fffffffffffffff/0", diff, borrow);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      start_op(64'd7, 64'd2, lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a        = 64'd100 + 64'(i);
         b        = 64'd1;
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 64'd5 || borrow !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL backpressure_stable got=%0d_bad_cycles exp=0", bad);
      end
      in_valid = 1'b0;
      drain();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL backpressure_release got=%b%b exp=10", in_ready, out_valid);
      end
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL backpressure_pulse_ignored got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen = 0;
      in_valid = 1'b1;
      a        = 64'd9;
      b        = 64'd1;
      step();
      in_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_mid_idle got=%b%b exp=10", in_ready, out_valid);
      end
      for (int i = 0; i < 15; i++) begin
         if (out_valid === 1'b1) seen++;
         step();
      end
      checks++;
      if (seen != 0) begin
         failures++; $display("FAIL reset_mid_no_valid got=%0d exp=0", seen);
      end
      start_op(64'd10, 64'd4, lat);
      checks++;
      if (lat !== 9 || diff !== 64'd6) begin
         failures++; $display("FAIL reset_mid_next got=%0d/%h exp=9/6", lat, diff);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int wait1 = 0;
      int gap   = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 64'd20;
      b         = 64'd7;
      while (!out_valid && wait1 < 40) begin
         step();
         wait1++;
      end
      checks++;
      if (out_valid !== 1'b1 || diff !== 64'd13) begin
         failures++; $display("FAIL b2b_first got=%b/%h exp=1/d", out_valid, diff);
      end
      step();
      gap = 1;
      while (!out_valid && gap < 40) begin
         step();
         gap++;
      end
      checks++;
      if (gap !== 10) begin
         failures++; $display("FAIL b2b_throughput got=%0d exp=10", gap);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      step();
   endtask

   task automatic test_single_digit();
      int lat;
      logic [15:0] exp_d;
      logic        exp_z;
`ifdef SUBTRACTOR_SATURATE_EN
      exp_d = 16'd0;
      exp_z = 1'b1;
`else
      exp_d = 16'hFFFF;
      exp_z = 1'b0;
`endif
      in_valid1 = 1'b1;
      a1        = 16'd0;
      b1        = 16'd1;
      step();
      in_valid1 = 1'b0;
      a1        = 16'h5555;
      lat       = 1;
      while (!out_valid1 && lat < 20) begin
         step();
         lat++;
      end
      checks++;
      if (lat !== 2) begin
         failures++; $display("FAIL n1_latency got=%0d exp=2", lat);
      end
      checks++;
      if (diff1 !== exp_d || borrow1 !== 1'b1 || zero1 !== exp_z) begin
         failures++;
         $display("FAIL n1_result got=%h/%b/%b exp=%h/1/%b", diff1, borrow1, zero1, exp_d, exp_z);
      end
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      in_valid1  = 1'b0;
      out_ready1 = 1'b0;
      a1         = '0;
      b1         = '0;
      test_reset();
      test_basic();
      test_underflow();
      test_equal_and_chain();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_single_digit();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
